// File: rtl/rx_frame_tracker_pkg.sv
// Framing symbol codes, per-lane symbol classes and tracker states shared by the
// receive framing tracker and its lane classifier.
package rx_frame_tracker_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  typedef enum logic [5:0] {
    TY_NONE      = 6'b000000,
    TY_DATA      = 6'b100000,
    TY_TLPSTART  = 6'b010000,
    TY_TLPEND    = 6'b001000,
    TY_DLLPEND   = 6'b000100,
    TY_DLLPSTART = 6'b000010,
    TY_TLPEDB    = 6'b000001
  } sym_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TLP  = 2'b01,
    ST_DLLP = 2'b10
  } frame_state_e;

endpackage

// File: rtl/rx_frame_tracker_if.sv
// Symbol input / classification output bundle of the receive framing tracker.
interface rx_frame_tracker_if #(
  parameter int LANES       = 4,
  parameter int MAX_PKT_LEN = 1024
);
  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

  logic [8*LANES-1:0] data_in;
  logic [LANES-1:0]   dk_in;
  logic               valid_in;
  logic               valid_out;
  logic [6*LANES-1:0] type_out;
  logic [1:0]         state_out;
  logic               pkt_done;
  logic               pkt_is_dllp;
  logic               pkt_nullified;
  logic [LEN_W-1:0]   pkt_len;
  logic               err_framing;
  logic               err_dllp_len;
  logic               err_overflow;

  modport master (
    output data_in, dk_in, valid_in,
    input  valid_out, type_out, state_out, pkt_done, pkt_is_dllp, pkt_nullified,
           pkt_len, err_framing, err_dllp_len, err_overflow
  );

  modport slave (
    input  data_in, dk_in, valid_in,
    output valid_out, type_out, state_out, pkt_done, pkt_is_dllp, pkt_nullified,
           pkt_len, err_framing, err_dllp_len, err_overflow
  );
endinterface

// File: rtl/rx_frame_tracker_classify.sv
// Single-lane framing classifier: given the packet state/count left by the previous
// lane, decodes one symbol and produces the state/count handed to the next lane.
module rx_frame_tracker_classify
  import rx_frame_tracker_pkg::*;
#(
  parameter int MAX_PKT_LEN = 1024,
  parameter int DLLP_LEN    = 6,
  parameter int LEN_W       = 11
) (
  input  logic [7:0]       sym,
  input  logic             is_k,
  input  frame_state_e     state_in,
  input  logic [LEN_W-1:0] count_in,
  output sym_type_e        sym_type,
  output frame_state_e     state_nxt,
  output logic [LEN_W-1:0] count_nxt,
  output logic             done,
  output logic             is_dllp,
  output logic             nullified,
  output logic             err_framing,
  output logic             err_dllp_len,
  output logic             err_overflow
);
  localparam logic [LEN_W-1:0] MAX_CNT  = LEN_W'(MAX_PKT_LEN);
  localparam logic [LEN_W-1:0] DLLP_CNT = LEN_W'(DLLP_LEN);

  always_comb begin
    sym_type     = TY_NONE;
    state_nxt    = state_in;
    count_nxt    = count_in;
    done         = 1'b0;
    is_dllp      = 1'b0;
    nullified    = 1'b0;
    err_framing  = 1'b0;
    err_dllp_len = 1'b0;
    err_overflow = 1'b0;
    if (is_k) begin
      case (sym)
        K_STP: begin
          sym_type    = TY_TLPSTART;
          state_nxt   = ST_TLP;
          count_nxt   = '0;
          err_framing = (state_in != ST_IDLE);
        end
        K_SDP: begin
          sym_type    = TY_DLLPSTART;
          state_nxt   = ST_DLLP;
          count_nxt   = '0;
          err_framing = (state_in != ST_IDLE);
        end
        K_END: begin
          state_nxt = ST_IDLE;
          case (state_in)
            ST_TLP: begin
              sym_type = TY_TLPEND;
              done     = 1'b1;
            end
            ST_DLLP: begin
              sym_type = TY_DLLPEND;
              if (count_in == DLLP_CNT) begin
                done    = 1'b1;
                is_dllp = 1'b1;
              end else begin
                err_dllp_len = 1'b1;
              end
            end
            default: err_framing = 1'b1;
          endcase
        end
        K_EDB: begin
          state_nxt = ST_IDLE;
          if (state_in == ST_TLP) begin
            sym_type  = TY_TLPEDB;
            nullified = 1'b1;
          end else begin
            err_framing = 1'b1;
          end
        end
        K_PAD: begin
        end
        default: begin
          err_framing = 1'b1;
          state_nxt   = ST_IDLE;
        end
      endcase
    end else begin
      case (state_in)
        ST_TLP: begin
          if (count_in == MAX_CNT) begin
            err_overflow = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            sym_type  = TY_DATA;
            count_nxt = count_in + LEN_W'(1);
          end
        end
        ST_DLLP: begin
          // Oversized DLLPs keep counting (saturated) so the length error shows at END.
          sym_type = TY_DATA;
          if (count_in != MAX_CNT) count_nxt = count_in + LEN_W'(1);
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: rtl/rx_frame_tracker.sv
// Multi-lane receive framing tracker: ripples packet state lane to lane within a
// cycle, registers it between cycles and reports per-lane classes and packet events.
module rx_frame_tracker
  import rx_frame_tracker_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int MAX_PKT_LEN = 1024,
  parameter int DLLP_LEN    = 6
) (
  input logic               clk,
  input logic               rst_n,
  rx_frame_tracker_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

  frame_state_e     state_q;
  logic [LEN_W-1:0] count_q;

  sym_type_e        lane_type [LANES];
  logic [LEN_W-1:0] lane_len  [LANES];
  logic [LANES-1:0] lane_done, lane_dllp, lane_null, lane_ef, lane_edl, lane_eov;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    frame_state_e     st_in, st_out;
    logic [LEN_W-1:0] cnt_in, cnt_out;

    // Per-block nets keep the lane ripple free of self-referencing vectors.
    if (i == 0) begin : g_first
      assign st_in  = state_q;
      assign cnt_in = count_q;
    end else begin : g_next
      assign st_in  = g_lane[i-1].st_out;
      assign cnt_in = g_lane[i-1].cnt_out;
    end

    assign lane_len[i] = cnt_in;

    rx_frame_tracker_classify #(
      .MAX_PKT_LEN (MAX_PKT_LEN),
      .DLLP_LEN    (DLLP_LEN),
      .LEN_W       (LEN_W)
    ) u_classify (
      .sym          (bus.data_in[8*i +: 8]),
      .is_k         (bus.dk_in[i]),
      .state_in     (st_in),
      .count_in     (cnt_in),
      .sym_type     (lane_type[i]),
      .state_nxt    (st_out),
      .count_nxt    (cnt_out),
      .done         (lane_done[i]),
      .is_dllp      (lane_dllp[i]),
      .nullified    (lane_null[i]),
      .err_framing  (lane_ef[i]),
      .err_dllp_len (lane_edl[i]),
      .err_overflow (lane_eov[i])
    );
  end

  logic [6*LANES-1:0] types_d;
  logic               done_d, dllp_d, null_d;
  logic [LEN_W-1:0]   len_d;

  always_comb begin
    types_d = '0;
    done_d  = 1'b0;
    dllp_d  = 1'b0;
    null_d  = 1'b0;
    len_d   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      types_d[6*i +: 6] = lane_type[i];
      if (lane_done[i] || lane_null[i]) begin
        done_d = lane_done[i];
        dllp_d = lane_dllp[i];
        null_d = lane_null[i];
        len_d  = lane_len[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      count_q           <= '0;
      bus.valid_out     <= 1'b0;
      bus.type_out      <= '0;
      bus.pkt_done      <= 1'b0;
      bus.pkt_is_dllp   <= 1'b0;
      bus.pkt_nullified <= 1'b0;
      bus.pkt_len       <= '0;
      bus.err_framing   <= 1'b0;
      bus.err_dllp_len  <= 1'b0;
      bus.err_overflow  <= 1'b0;
    end else begin
      bus.valid_out <= bus.valid_in;
      if (bus.valid_in) begin
        state_q           <= g_lane[LANES-1].st_out;
        count_q           <= g_lane[LANES-1].cnt_out;
        bus.type_out      <= types_d;
        bus.pkt_done      <= done_d;
        bus.pkt_is_dllp   <= dllp_d;
        bus.pkt_nullified <= null_d;
        bus.pkt_len       <= len_d;
        bus.err_framing   <= |lane_ef;
        bus.err_dllp_len  <= |lane_edl;
        bus.err_overflow  <= |lane_eov;
      end else begin
        bus.type_out      <= '0;
        bus.pkt_done      <= 1'b0;
        bus.pkt_is_dllp   <= 1'b0;
        bus.pkt_nullified <= 1'b0;
        bus.pkt_len       <= '0;
        bus.err_framing   <= 1'b0;
        bus.err_dllp_len  <= 1'b0;
        bus.err_overflow  <= 1'b0;
      end
    end
  end

  assign bus.state_out = state_q;
endmodule
